mips_mc_ctrl: RTL and testbench
===============================

// Module: mips_mc_ctrl
// PURPOSE
//  Multi-cycle main controller for the MIPS core: sequences the shared datapath (PC, IR, GRF, ALU, DM)
//  through IF/ID/EX/MEM/WB states, one instruction at a time. Decodes op/funct from the IR and drives
//  every write enable and mux select. Sits beside the datapath inside mips; replaces single-cycle decode.
// PARAMETERS
//  RA_IDX    5'd31  GRF index written by jal
//  CNT_W     32     width of retire counter (only used when MC_RETIRE_CNT_EN defined)
// PORTS
//  clk        in   1      system clock, rising edge
//  reset      in   1      asynchronous, active-low reset (0 = in reset)
//  run        in   1      1 = may start a new instruction; 0 = hold in IF with no writes
//  op         in   6      IR[31:26], valid from cycle after IF
//  funct      in   6      IR[5:0]
//  zero       in   1      ALU equal flag (rs==rt), valid in EX
//  pc_we      out  1      PC write enable
//  pc_sel     out  2      0 pc+4, 1 pc+4+(simm<<2), 2 {pc[31:28],imm26,00}, 3 GRF[rs]
//  ir_we      out  1      IR write enable
//  rf_we      out  1      GRF write enable
//  rf_a3_sel  out  2      0 rt, 1 rd, 2 RA_IDX
//  rf_wd_sel  out  2      0 ALU result, 1 DM read data, 2 PC (already pc+4)
//  ext_op     out  2      0 zero-ext, 1 sign-ext, 2 imm<<16
//  alu_b_sel  out  1      0 GRF[rt], 1 extended immediate
//  alu_op     out  3      0 add, 1 sub, 2 or
//  dm_we      out  1      DM write enable
//  state      out  3      current state encoding (debug)
//  illegal    out  1      1-cycle pulse in ID on unsupported op/funct
//  retire_cnt out  CNT_W  instructions completed
// BEHAVIOUR
//  States: IF=0, ID=1, EX=2, MEM=3, WB=4; others unreachable, recover to IF next edge.
//  Reset (reset=0, async): state=IF, retire_cnt=0; all enables/illegal forced 0 combinationally
//   while reset low; selects 0. First IF issues on first rising edge after release with run=1.
//  Outputs combinational from state+op/funct; default 0 in every state unless listed.
//  IF : run=1 -> ir_we=1, pc_we=1, pc_sel=0; next ID. run=0 -> all 0, stay IF (no retire).
//  ID : jal(03): rf_we=1,a3_sel=2,wd_sel=2,pc_we=1,pc_sel=2 -> IF (retire).
//       jr (00/08): pc_we=1,pc_sel=3 -> IF (retire). nop (op 00/funct 00): -> IF (retire).
//       addu(00/21),subu(00/23),ori(0d),lui(0f),lw(23),sw(2b),beq(04) -> EX.
//       anything else: illegal=1 -> IF, treated as nop (retire).
//  EX : addu alu_op=0, subu alu_op=1, b_sel=0 -> WB. ori ext_op=0,b_sel=1,alu_op=2 -> WB.
//       lui ext_op=2,b_sel=1,alu_op=2 (rs=$0) -> WB. lw/sw ext_op=1,b_sel=1,alu_op=0 -> MEM.
//       beq alu_op=1,ext_op=1; pc_we=zero, pc_sel=1 -> IF (retire).
//  MEM: sw dm_we=1 -> IF (retire). lw ext_op=1,b_sel=1,alu_op=0 held -> WB.
//  WB : rf_we=1; R-type a3_sel=1 wd_sel=0; ori/lui a3_sel=0 wd_sel=0; lw a3_sel=0 wd_sel=1 -> IF (retire).
//   EX/MEM/WB hold alu_op/ext_op/b_sel of the instruction so datapath inputs stay stable.
//  CPI: jal/jr/nop/illegal 2, beq 3, sw 4, R/ori/lui 4, lw 5.
//  run only sampled in IF; dropping run mid-instruction does not stall it.
//  Async reset mid-instruction aborts immediately: no partial write, state=IF.
//  op/funct assumed stable from ID through end of instruction (IR only written in IF).
// CONFIGURATION
//  MC_RETIRE_CNT_EN defined: retire_cnt += 1 on every edge leaving a "retire" transition above;
//   wraps 2^CNT_W-1 -> 0; cleared by reset. Undefined: retire_cnt tied to 0, no counter flops.
// TESTING
//  reset=0 any time, clk running -> all enables 0, state=0; release with run=0 -> stays IF, pc_we=0.
//  run=1, addu $3,$1,$2 -> states 0,1,2,4,0; WB rf_we=1,a3_sel=1,wd_sel=0; retire_cnt 0->1.
//  lw then sw -> lw states 0,1,2,3,4 with wd_sel=1 in WB; sw dm_we=1 only in MEM; no rf_we.
//  beq zero=1 -> EX pc_we=1,pc_sel=1; zero=0 -> EX pc_we=0; both return to IF after 3 cycles.
//  jal -> ID: rf_we=1,a3_sel=2,wd_sel=2,pc_sel=2; op=6'h3f -> illegal=1 one cycle, no writes.
//  reset pulled low during MEM of sw -> dm_we drops same cycle, state=IF; with MC_RETIRE_CNT_EN
//   preload cnt near max, run 2 nops -> wraps to 0.

Source files
------------

// File: rtl/mips_mc_ctrl.sv
`default_nettype none
// ============================================================================
// mips_mc_ctrl : multi-cycle IF/ID/EX/MEM/WB main controller for the MIPS core
// Optional retire counter enabled by defining MC_RETIRE_CNT_EN.
// Revision: 1.0
// ============================================================================
module mips_mc_ctrl #(
   parameter logic [4:0] RA_IDX = 5'd31,
   parameter int         CNT_W  = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic [5:0]       op,
   input  logic [5:0]       funct,
   input  logic             zero,
   output logic             pc_we,
   output logic [1:0]       pc_sel,
   output logic             ir_we,
   output logic             rf_we,
   output logic [1:0]       rf_a3_sel,
   output logic [1:0]       rf_wd_sel,
   output logic [1:0]       ext_op,
   output logic             alu_b_sel,
   output logic [2:0]       alu_op,
   output logic             dm_we,
   output logic [2:0]       state,
   output logic             illegal,
   output logic [CNT_W-1:0] retire_cnt
);

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EX  = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;
   localparam logic [5:0] FN_NOP   = 6'h00;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;

   state_t state_q, state_d;
   logic   retire;

   logic is_r, is_addu, is_subu, is_jr, is_nop;
   logic is_jal, is_beq, is_ori, is_lui, is_lw, is_sw, to_ex;

   assign is_r    = (op == OP_RTYPE);
   assign is_addu = is_r && (funct == FN_ADDU);
   assign is_subu = is_r && (funct == FN_SUBU);
   assign is_jr   = is_r && (funct == FN_JR);
   assign is_nop  = is_r && (funct == FN_NOP);
   assign is_jal  = (op == OP_JAL);
   assign is_beq  = (op == OP_BEQ);
   assign is_ori  = (op == OP_ORI);
   assign is_lui  = (op == OP_LUI);
   assign is_lw   = (op == OP_LW);
   assign is_sw   = (op == OP_SW);
   assign to_ex   = is_addu | is_subu | is_ori | is_lui | is_lw | is_sw | is_beq;

   // ALU/extender controls held for the whole EX..WB span of an instruction
   logic [2:0] alu_h;
   logic [1:0] ext_h;
   logic       b_h;

   always_comb begin
      alu_h = 3'd0;
      ext_h = 2'd0;
      b_h   = 1'b0;
      if (is_subu) begin
         alu_h = 3'd1;
      end else if (is_ori) begin
         ext_h = 2'd0; b_h = 1'b1; alu_h = 3'd2;
      end else if (is_lui) begin
         ext_h = 2'd2; b_h = 1'b1; alu_h = 3'd2;
      end else if (is_lw || is_sw) begin
         ext_h = 2'd1; b_h = 1'b1; alu_h = 3'd0;
      end else if (is_beq) begin
         ext_h = 2'd1; alu_h = 3'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IF;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      pc_we     = 1'b0;
      pc_sel    = 2'd0;
      ir_we     = 1'b0;
      rf_we     = 1'b0;
      rf_a3_sel = 2'd0;
      rf_wd_sel = 2'd0;
      ext_op    = 2'd0;
      alu_b_sel = 1'b0;
      alu_op    = 3'd0;
      dm_we     = 1'b0;
      illegal   = 1'b0;
      retire    = 1'b0;
      case (state_q)
         S_IF: begin
            if (run) begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               state_d = S_ID;
            end
         end
         S_ID: begin
            if (is_jal) begin
               rf_we     = 1'b1;
               rf_a3_sel = 2'd2;
               rf_wd_sel = 2'd2;
               pc_we     = 1'b1;
               pc_sel    = 2'd2;
               retire    = 1'b1;
               state_d   = S_IF;
            end else if (is_jr) begin
               pc_we   = 1'b1;
               pc_sel  = 2'd3;
               retire  = 1'b1;
               state_d = S_IF;
            end else if (is_nop) begin
               retire  = 1'b1;
               state_d = S_IF;
            end else if (to_ex) begin
               state_d = S_EX;
            end else begin
               illegal = 1'b1;
               retire  = 1'b1;
               state_d = S_IF;
            end
         end
         S_EX: begin
            alu_op    = alu_h;
            ext_op    = ext_h;
            alu_b_sel = b_h;
            if (is_beq) begin
               pc_we   = zero;
               pc_sel  = 2'd1;
               retire  = 1'b1;
               state_d = S_IF;
            end else if (is_lw || is_sw) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            alu_op    = alu_h;
            ext_op    = ext_h;
            alu_b_sel = b_h;
            if (is_sw) begin
               dm_we   = 1'b1;
               retire  = 1'b1;
               state_d = S_IF;
            end else begin
               state_d = S_WB;
            end
         end
         S_WB: begin
            alu_op    = alu_h;
            ext_op    = ext_h;
            alu_b_sel = b_h;
            rf_we     = 1'b1;
            rf_a3_sel = is_r  ? 2'd1 : 2'd0;
            rf_wd_sel = is_lw ? 2'd1 : 2'd0;
            retire    = 1'b1;
            state_d   = S_IF;
         end
         default: state_d = S_IF;
      endcase
      // Held in reset: nothing may be written while the datapath is being cleared
      if (!reset) begin
         pc_we     = 1'b0;
         pc_sel    = 2'd0;
         ir_we     = 1'b0;
         rf_we     = 1'b0;
         rf_a3_sel = 2'd0;
         rf_wd_sel = 2'd0;
         ext_op    = 2'd0;
         alu_b_sel = 1'b0;
         alu_op    = 3'd0;
         dm_we     = 1'b0;
         illegal   = 1'b0;
         retire    = 1'b0;
      end
   end

   assign state = state_q;

`ifdef MC_RETIRE_CNT_EN
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      cnt_q <= '0;
      else if (retire) cnt_q <= cnt_q + 1'b1;
   end

   assign retire_cnt = cnt_q;

   logic unused_ok;
   assign unused_ok = ^RA_IDX;
`else
   assign retire_cnt = '0;

   logic unused_ok;
   assign unused_ok = ^{RA_IDX, retire};
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips_mc_ctrl.sv
`default_nettype none
// Testbench for mips_mc_ctrl: scoreboard of expected per-cycle control vectors.
module tb_mips_mc_ctrl;

`ifdef MC_RETIRE_CNT_EN
   localparam int TB_CNT_W = 2;
`else
   localparam int TB_CNT_W = 32;
`endif

   logic                clk = 1'b0;
   logic                reset = 1'b0;
   logic                run = 1'b0;
   logic [5:0]          op = 6'h00;
   logic [5:0]          funct = 6'h00;
   logic                zero = 1'b0;
   logic                pc_we, ir_we, rf_we, alu_b_sel, dm_we, illegal;
   logic [1:0]          pc_sel, rf_a3_sel, rf_wd_sel, ext_op;
   logic [2:0]          alu_op, state;
   logic [TB_CNT_W-1:0] retire_cnt;

   mips_mc_ctrl #(.RA_IDX(5'd31), .CNT_W(TB_CNT_W)) dut (
      .clk(clk), .reset(reset), .run(run), .op(op), .funct(funct), .zero(zero),
      .pc_we(pc_we), .pc_sel(pc_sel), .ir_we(ir_we), .rf_we(rf_we),
      .rf_a3_sel(rf_a3_sel), .rf_wd_sel(rf_wd_sel), .ext_op(ext_op),
      .alu_b_sel(alu_b_sel), .alu_op(alu_op), .dm_we(dm_we), .state(state),
      .illegal(illegal), .retire_cnt(retire_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] st;
      logic       pcwe;
      logic [1:0] pcsel;
      logic       irwe;
      logic       rfwe;
      logic [1:0] a3;
      logic [1:0] wd;
      logic [1:0] ext;
      logic       b;
      logic [2:0] alu;
      logic       dm;
      logic       ill;
   } row_t;

   row_t                exp_q[$];
   int                  checks = 0;
   int                  errors = 0;
   logic [TB_CNT_W-1:0] exp_cnt = '0;

   function automatic row_t mk(input logic [2:0] st, input logic pcwe, input logic [1:0] pcsel,
                               input logic irwe, input logic rfwe, input logic [1:0] a3,
                               input logic [1:0] wd, input logic [1:0] ext, input logic b,
                               input logic [2:0] alu, input logic dm, input logic ill);
      return {st, pcwe, pcsel, irwe, rfwe, a3, wd, ext, b, alu, dm, ill};
   endfunction

   function automatic row_t observed();
      return {state, pc_we, pc_sel, ir_we, rf_we, rf_a3_sel, rf_wd_sel, ext_op,
              alu_b_sel, alu_op, dm_we, illegal};
   endfunction

   // Reference cycle tables, one row per clock, derived per instruction
   task automatic push_rows(input logic [5:0] o, input logic [5:0] f, input logic z);
      exp_q.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      if (o == 6'h03)
         exp_q.push_back(mk(1, 1, 2, 0, 1, 2, 2, 0, 0, 0, 0, 0));
      else if (o == 6'h00 && f == 6'h08)
         exp_q.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      else if (o == 6'h00 && f == 6'h00)
         exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      else if (o == 6'h00 && f == 6'h21) begin
         exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
         exp_q.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
         exp_q.push_back(mk(4, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
      end else if (o == 6'h00 && f == 6'h23) begin
         exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
         exp_q.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
         exp_q.push_back(mk(4, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0));
      end else if (o == 6'h0d) begin
         exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
         exp_q.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0));
         exp_q.push_back(mk(4, 0, 0, 0, 1, 0, 0, 0, 1, 2, 0, 0));
      end else if (o == 6'h0f) begin
         exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
         exp_q.push_back(mk(2, 0, 0, 0, 0, 0, 0, 2, 1, 2, 0, 0));
         exp_q.push_back(mk(4, 0, 0, 0, 1, 0, 0, 2, 1, 2, 0, 0));
      end else if (o == 6'h23) begin
         exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
         exp_q.push_back(mk(2, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
         exp_q.push_back(mk(3, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
         exp_q.push_back(mk(4, 0, 0, 0, 1, 0, 1, 1, 1, 0, 0, 0));
      end else if (o == 6'h2b) begin
         exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
         exp_q.push_back(mk(2, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
         exp_q.push_back(mk(3, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0));
      end else if (o == 6'h04) begin
         exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
         exp_q.push_back(mk(2, z, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0));
      end else
         exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
   endtask

   // Entered and left at 1 time unit after a rising edge with the DUT in IF
   task automatic do_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                           input logic z, input bit drop_run);
      row_t exp_r, act_r;
      int   cyc;
      op = o; funct = f; zero = z; run = 1'b1;
      push_rows(o, f, z);
      cyc = 0;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         exp_r = exp_q.pop_front();
         act_r = observed();
         checks++;
         if (act_r !== exp_r) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h required %h", name, cyc, act_r, exp_r);
         end
         @(posedge clk); #1;
         if (drop_run) run = 1'b0;
         cyc++;
      end
      run = 1'b0;
`ifdef MC_RETIRE_CNT_EN
      exp_cnt = exp_cnt + 1'b1;
`endif
      checks++;
      if (state !== 3'd0 || retire_cnt !== exp_cnt) begin
         errors++;
         $display("FAIL %s end: state %0d cnt %0d required state 0 cnt %0d",
                  name, state, retire_cnt, exp_cnt);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; run = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (observed() !== row_t'(0) || retire_cnt !== '0) begin
         errors++;
         $display("FAIL reset_state: got %h cnt %0d required 0", observed(), retire_cnt);
      end
      run = 1'b0;
      reset = 1'b1;
      exp_cnt = '0;
   endtask

   task automatic test_idle();
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (state !== 3'd0 || pc_we !== 1'b0 || ir_we !== 1'b0) begin
            errors++;
            $display("FAIL idle: state %0d pc_we %b ir_we %b required 0 0 0", state, pc_we, ir_we);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_abort();
      op = 6'h2b; funct = 6'h00; run = 1'b1;
      repeat (3) @(posedge clk);
      #1 run = 1'b0;
      checks++;
      if (state !== 3'd3 || dm_we !== 1'b1) begin
         errors++;
         $display("FAIL abort_pre: state %0d dm_we %b required 3 1", state, dm_we);
      end
      #2 reset = 1'b0;
      #1;
      exp_cnt = '0;
      checks++;
      if (state !== 3'd0 || dm_we !== 1'b0 || retire_cnt !== '0) begin
         errors++;
         $display("FAIL abort_reset: state %0d dm_we %b cnt %0d required 0 0 0",
                  state, dm_we, retire_cnt);
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_idle();
      do_instr("addu", 6'h00, 6'h21, 1'b0, 1'b0);
      do_instr("subu", 6'h00, 6'h23, 1'b0, 1'b0);
      do_instr("ori", 6'h0d, 6'h15, 1'b0, 1'b0);
      do_instr("lui", 6'h0f, 6'h00, 1'b0, 1'b0);
      do_instr("lw", 6'h23, 6'h04, 1'b0, 1'b0);
      do_instr("sw", 6'h2b, 6'h08, 1'b0, 1'b0);
      do_instr("beq_taken", 6'h04, 6'h00, 1'b1, 1'b0);
      do_instr("beq_not_taken", 6'h04, 6'h00, 1'b0, 1'b0);
      do_instr("jal", 6'h03, 6'h00, 1'b0, 1'b0);
      do_instr("jr", 6'h00, 6'h08, 1'b0, 1'b0);
      do_instr("nop", 6'h00, 6'h00, 1'b0, 1'b0);
      do_instr("illegal_op", 6'h3f, 6'h00, 1'b0, 1'b0);
      do_instr("illegal_funct", 6'h00, 6'h2a, 1'b0, 1'b0);
      do_instr("lw_run_drop", 6'h23, 6'h00, 1'b0, 1'b1);
      test_idle();
      test_abort();
      repeat (5) do_instr("nop_wrap", 6'h00, 6'h00, 1'b0, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
